serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial W-bit subtractor computing D = A - B, LSB first, one bit per clock.
//  It is the inverse-operation companion to the team's combinational ripple adder.
//  Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
//  One operation is in flight at a time; there is no overlap between result drain and new accept.
// PARAMETERS
//  W  4  operand/result width in bits; W >= 2
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  reset, asynchronous assert, active-low
//  in_valid   in   1  operands A,B valid
//  in_ready   out  1  block can accept operands
//  A          in   W  minuend
//  B          in   W  subtrahend
//  out_valid  out  1  D/BOUT (and OVF) valid
//  out_ready  in   1  consumer takes result
//  D          out  W  difference, A-B mod 2^W
//  BOUT       out  1  borrow out; 1 iff A < B (unsigned)
//  OVF        out  1  signed overflow; port exists only under SUB_OVF_EN
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; D=0; BOUT=0; OVF=0; out_valid=0; borrow=0; count=0; in_ready forced 0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept on rising edge with in_valid&in_ready: latch A,B into shift regs; borrow=0; count=0; go RUN.
//  RUN: in_ready=0. Each edge processes bit i=count:
//    d_i = a^b^br;  br' = (~a&b) | (~(a^b)&br);  d_i shifts into D from MSB side; count++.
//    On the edge processing bit W-1: BOUT=br'; state=DONE; out_valid=1.
//  Latency: out_valid rises exactly W clock edges after the accept edge.
//  DONE: out_valid=1; D/BOUT/OVF held stable while out_ready=0 (unbounded backpressure).
//    On edge with out_valid&out_ready: out_valid=0; go IDLE. in_ready=1 from the next cycle. D keeps its last value.
//  in_valid during RUN/DONE: ignored; no operands latched.
//  out_ready during IDLE/RUN: no effect.
//  A==B: D=0, BOUT=0.  A<B: BOUT=1, D is the two's-complement wrap.
//  Reset mid-RUN or mid-DONE: operation aborted; result discarded; out_valid=0; back to IDLE after release.
//  count width $clog2(W+1); no wrap beyond W-1 (FSM leaves RUN).
// CONFIGURATION
//  SUB_OVF_EN defined: OVF port present.
//    OVF = (A[W-1]^B[W-1]) & (A[W-1]^D[W-1]), registered with BOUT and valid with out_valid; reset 0.
//  SUB_OVF_EN undefined: no OVF port and no MSB-capture logic; all other behaviour identical.
// STRUCTURE
//  Package serial_sub_pkg:
//    state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//    borrow reset constant BORROW_INIT=1'b0.
//  Sub-module full_subtractor_cell (a, b, bin -> d, bout): combinational, instantiated once on the serial bit path.
//  Top: FSM, bit counter, A/B/D shift registers, borrow flop, handshake decode.
// TESTING (W=4; cycle counts measured from the accept edge)
//  1. A=9,B=3 -> D=6, BOUT=0; out_valid at edge 4, in_ready=0 during edges 1-4.
//  2. A=3,B=9 -> D=0xA, BOUT=1; OVF=1 under SUB_OVF_EN.
//  3. A=0xF,B=0xF -> D=0, BOUT=0, OVF=0.
//  4. A=8,B=1 -> D=7, BOUT=0, OVF=1 under SUB_OVF_EN.
//  5. Backpressure: out_ready=0 for 5 cycles with in_valid=1, A=2, B=1 presented in DONE
//     -> D/BOUT stable, nothing accepted; out_ready=1 -> IDLE, in_ready=1 next cycle.
//  6. rst_n low 1 cycle at RUN count=2 -> out_valid stays 0, D=0; after release in_ready=1 and a new op (5-5) gives D=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Package for the bit-serial subtractor.
// Holds the FSM state encoding and the initial borrow value loaded on accept.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic BORROW_INIT = 1'b0;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit
//   bout - borrow out
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, D = A - B, processed LSB first at one bit per clock.
// valid/ready handshake on the operand and result sides; one operation in flight.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output OVF.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  - operand handshake
//   A, B                - minuend, subtrahend
//   out_valid, out_ready- result handshake
//   D                   - difference, A - B mod 2^W
//   BOUT                - borrow out, 1 iff A < B (unsigned)
//   OVF                 - signed overflow (SUB_OVF_EN only)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] D,
  output logic         BOUT
`ifdef SUB_OVF_EN
  ,
  output logic         OVF
`endif
);

  localparam int unsigned CW = $clog2(W + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   d_q, d_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic           out_valid_q, out_valid_d;
`ifdef SUB_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic diff_bit;
  logic borrow_nxt;

  full_subtractor_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (diff_bit),
    .bout (borrow_nxt)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    br_d        = br_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
`ifdef SUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          br_d    = BORROW_INIT;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Result enters at the MSB so after W shifts bit 0 lands in D[0].
        d_d     = {diff_bit, d_q[W-1:1]};
        br_d    = borrow_nxt;
        count_d = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          bout_d      = borrow_nxt;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SUB_OVF_EN
          // On the last bit a_q[0]/b_q[0] are the operand sign bits.
          ovf_d = (a_q[0] ^ b_q[0]) & (a_q[0] ^ diff_bit);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      br_q        <= BORROW_INIT;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      br_q        <= br_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
`ifdef SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Held low while reset is asserted.
  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign BOUT      = bout_q;
`ifdef SUB_OVF_EN
  assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): directed cases, random operands,
// backpressure and mid-operation reset, checked against an arithmetic reference.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_out;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d_out),
    .BOUT      (bout)
`ifdef SUB_OVF_EN
    ,
    .OVF       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic.
  function automatic logic [W-1:0] ref_diff(input int a, input int b);
    int r;
    r = (a - b + (1 << W)) % (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input int a, input int b);
    return a < b;
  endfunction

  function automatic logic ref_ovf(input int a, input int b);
    int sa, sb, r;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // Accept an operation and check in_ready/out_valid timing up to DONE, then the result.
  task automatic run_op(input int a, input int b, input string tag);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    a_in     = a[W-1:0];
    b_in     = b[W-1:0];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      step();
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      check({tag, "_out_valid_edge"}, 32'(out_valid), (k == W) ? 32'd1 : 32'd0);
    end
    check({tag, "_D"}, 32'(d_out), 32'(ref_diff(a, b)));
    check({tag, "_BOUT"}, 32'(bout), 32'(ref_borrow(a, b)));
`ifdef SUB_OVF_EN
    check({tag, "_OVF"}, 32'(ovf), 32'(ref_ovf(a, b)));
`endif
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held_d;
    logic         held_b;
    int           ra, rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(d_out), 32'd0);
    check("rst_BOUT", 32'(bout), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    run_op(9, 3, "t1");   drain("t1");
    run_op(3, 9, "t2");   drain("t2");
    run_op(15, 15, "t3"); drain("t3");
    run_op(8, 1, "t4");   drain("t4");

    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      run_op(ra, rb, "rnd");
      // Random consumer delay before draining.
      repeat ($urandom_range(0, 3)) step();
      check("rnd_hold_valid", 32'(out_valid), 32'd1);
      drain("rnd");
    end

    // Backpressure with new operands offered while DONE.
    run_op(7, 2, "bp");
    held_d   = d_out;
    held_b   = bout;
    a_in     = 4'd2;
    b_in     = 4'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_D_stable", 32'(d_out), 32'(held_d));
      check("bp_BOUT_stable", 32'(bout), 32'(held_b));
    end
    in_valid = 1'b0;
    drain("bp");
    check("bp_D_kept", 32'(d_out), 32'(held_d));
    step();
    check("bp_no_accept", 32'(out_valid), 32'd0);
    check("bp_still_idle", 32'(in_ready), 32'd1);

    // Reset mid-RUN after two bits processed.
    a_in     = 4'd9;
    b_in     = 4'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_D", 32'(d_out), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_op(5, 5, "t6");
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
